sort_window_loader: RTL and testbench
=====================================

// Module: sort_window_loader
// PURPOSE
//  Upstream feeder for the 8-input byte sorter. Accepts a serial valid/ready stream of
//  bytes, packs them into an N_ELEM-wide frame and presents the frame in parallel with a
//  valid/ready handshake. The frame is double-buffered: the next frame fills while the
//  sorter consumes the previous one.
// PARAMETERS
//  DATA_W   8   width of one sample
//  N_ELEM   8   samples per frame (>=2); element 0 drives sorter input a, element 7 drives h
// PORTS
//  clk        in   1               single clock, rising edge
//  rst_n      in   1               asynchronous active-low reset
//  clr        in   1               sync clear: drop partial fill and pending frame
//  in_data    in   DATA_W          serial sample
//  in_valid   in   1               sample offered
//  in_ready   out  1               sample accepted when in_valid && in_ready
//  out_data   out  N_ELEM*DATA_W   frame; element k at [k*DATA_W +: DATA_W]
//  out_valid  out  1               frame held for sorter
//  out_ready  in   1               sorter takes frame when out_valid && out_ready
//  fill_cnt   out  $clog2(N_ELEM)+1  samples in fill bank (0..N_ELEM-1)
//  frame_cnt  out  16              frames delivered (out handshakes), wraps 0xFFFF->0
// BEHAVIOUR
//  - Reset (async, rst_n=0): fill bank, out_data, fill_cnt, frame_cnt = 0; out_valid = 0.
//  - Fill bank: accepted sample written to element fill_cnt; fill_cnt increments.
//  - Frame complete when sample is accepted at fill_cnt==N_ELEM-1: fill bank + that sample
//    load out_data on the same edge, out_valid=1, fill_cnt->0. Latency: out_valid high the
//    cycle after the last sample's accept edge.
//  - in_ready = !clr && (fill_cnt!=N_ELEM-1 || !out_valid || out_ready); combinational path
//    out_ready->in_ready is intended (no bubble under continuous flow).
//  - Out handshake without new frame: out_valid->0, frame_cnt++. With new frame on same edge:
//    out_data reloads, out_valid stays 1, frame_cnt++.
//  - out_data stable while out_valid && !out_ready.
//  - clr=1: fill_cnt->0, out_valid->0, frame_cnt kept; clr wins over any in/out handshake
//    that cycle (no frame counted).
//  - Reset mid-frame: partial samples lost, no partial frame ever emitted.
//  - in_valid without in_ready: sample not taken, upstream must hold.
// CONFIGURATION
//  SLIDING_WINDOW_EN defined: after the first N_ELEM samples, every accepted sample shifts
//  the window (element 0 dropped, elements move down one, new sample into element N_ELEM-1)
//  and loads a new frame -> one frame per sample for median filtering; fill_cnt saturates
//  at N_ELEM-1 once primed; in_ready = !clr && (!primed || !out_valid || out_ready);
//  clr also clears primed.
//  Not defined: block mode above, non-overlapping frames.
// STRUCTURE
//  - sort_pkg: DATA_W, N_ELEM localparams, typedef elem_t (logic [DATA_W-1:0]),
//    typedef frame_t (elem_t [N_ELEM-1:0]), fill_state_e {S_FILL, S_PRIMED}.
//  - Sub-module window_shift_reg: N_ELEM x DATA_W register file with indexed write
//    (block mode) and shift-in (sliding mode); top holds counters and handshake logic.
// TESTING
//  1 Feed 1,2,12,8,4,10,6,3 back-to-back, out_ready=1 -> one cycle after 8th accept
//    out_valid=1, elements 0..7 = 1,2,12,8,4,10,6,3; frame_cnt=1.
//  2 out_ready=0, feed 16 samples continuously -> in_ready drops at fill_cnt=7 of frame 2,
//    out_data holds frame 1; raise out_ready -> frame 2 loads same edge, no sample lost.
//  3 Feed 5 samples, pulse clr with in_valid=1 -> fill_cnt=0, sample that cycle dropped,
//    next 8 samples form a clean frame.
//  4 rst_n low for 1 cycle mid-frame (asynchronous, off clock edge) -> all outputs 0 at
//    once; next frame built only from post-reset samples.
//  5 Force frame_cnt near 0xFFFF via 2 frames from 0xFFFE -> wraps to 0x0000.
//  6 SLIDING_WINDOW_EN: feed 1..9 -> frame {1..8} then {2..9} on consecutive handshakes.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared types and sizes for the sort window loader.
package sort_pkg;

    localparam int DATA_W = 8;
    localparam int N_ELEM = 8;
    localparam int IDX_W  = $clog2(N_ELEM);
    localparam int CNT_W  = $clog2(N_ELEM) + 1;

    typedef logic [DATA_W-1:0] elem_t;
    typedef elem_t [N_ELEM-1:0] frame_t;

    typedef enum logic {
        S_FILL   = 1'b0,
        S_PRIMED = 1'b1
    } fill_state_e;

endpackage

// File: rtl/sort_window_loader_shift_reg.sv
// Fill bank for the window loader: N_ELEM x DATA_W registers with an indexed
// write (block fill) and a shift-in at the top element (sliding window).
// bank_next_o exposes the post-write contents so the top can load a frame on
// the same edge that the last sample lands.
module window_shift_reg
    import sort_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic             shift_en_i,
    input  elem_t            data_i,
    output frame_t           bank_next_o
);

    frame_t bank_q, bank_d;

    // Next bank contents: shift drops element 0 and appends at N_ELEM-1.
    always_comb begin
        bank_d = bank_q;
        if (shift_en_i) begin
            bank_d = {data_i, bank_q[N_ELEM-1:1]};
        end else if (wr_en_i) begin
            bank_d[wr_idx_i] = data_i;
        end
    end

    // Bank register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q <= '0;
        end else begin
            bank_q <= bank_d;
        end
    end

    assign bank_next_o = bank_d;

endmodule

// File: rtl/sort_window_loader.sv
// Serial-to-frame loader feeding the 8-input byte sorter. Samples are packed
// into a fill bank and handed over as a parallel frame with valid/ready; the
// next frame fills while the previous one waits for the sorter.
// Optional: SLIDING_WINDOW_EN turns it into a one-frame-per-sample sliding
// window once the first N_ELEM samples have arrived.
//
// state    | meaning (sliding build only)
// S_FILL   | collecting the first N_ELEM samples, indexed writes
// S_PRIMED | window full, each sample shifts in and emits a frame
module sort_window_loader
    import sort_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [N_ELEM*DATA_W-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CNT_W-1:0]         fill_cnt,
    output logic [15:0]              frame_cnt
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_ELEM - 1);

    logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
    logic             out_valid_q, out_valid_d;
    frame_t           out_data_q, out_data_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    frame_t           bank_next;

    logic at_last, accept, out_hs, bank_wr, bank_shift, load_frame;

    assign at_last = (fill_cnt_q == LAST_IDX);
    assign accept  = in_valid && in_ready;
    assign out_hs  = out_valid_q && out_ready;

`ifdef SLIDING_WINDOW_EN
    fill_state_e state_q, state_d;
    logic        primed;

    assign primed     = (state_q == S_PRIMED);
    assign in_ready   = !clr && (!primed || !out_valid_q || out_ready);
    assign bank_wr    = accept && !primed;
    assign bank_shift = accept && primed;
    assign load_frame = accept && (primed || at_last);
`else
    // The out_ready -> in_ready path lets the last sample of a frame land on
    // the same edge the sorter takes the previous frame.
    assign in_ready   = !clr && (!at_last || !out_valid_q || out_ready);
    assign bank_wr    = accept;
    assign bank_shift = 1'b0;
    assign load_frame = accept && at_last;
`endif

    window_shift_reg u_bank (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en_i     (bank_wr),
        .wr_idx_i    (fill_cnt_q[IDX_W-1:0]),
        .shift_en_i  (bank_shift),
        .data_i      (in_data),
        .bank_next_o (bank_next)
    );

    // Next-state for counters, frame register and window state; clr overrides
    // every handshake in its cycle.
    always_comb begin
        fill_cnt_d  = fill_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        frame_cnt_d = frame_cnt_q;
`ifdef SLIDING_WINDOW_EN
        state_d     = state_q;
`endif
        if (clr) begin
            fill_cnt_d  = '0;
            out_valid_d = 1'b0;
`ifdef SLIDING_WINDOW_EN
            state_d     = S_FILL;
`endif
        end else begin
            if (out_hs) begin
                out_valid_d = 1'b0;
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
            if (bank_wr) begin
`ifdef SLIDING_WINDOW_EN
                fill_cnt_d = at_last ? LAST_IDX : fill_cnt_q + CNT_W'(1);
                if (at_last) begin
                    state_d = S_PRIMED;
                end
`else
                fill_cnt_d = at_last ? '0 : fill_cnt_q + CNT_W'(1);
`endif
            end
            if (load_frame) begin
                out_data_d  = bank_next;
                out_valid_d = 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            frame_cnt_q <= '0;
`ifdef SLIDING_WINDOW_EN
            state_q     <= S_FILL;
`endif
        end else begin
            fill_cnt_q  <= fill_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef SLIDING_WINDOW_EN
            state_q     <= state_d;
`endif
        end
    end

    assign fill_cnt  = fill_cnt_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_sort_window_loader.sv
// Directed bench for sort_window_loader (block mode by default; the sliding
// window scenario runs when SLIDING_WINDOW_EN is defined).
module tb_sort_window_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  fill_cnt;
    logic [15:0] frame_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    sort_window_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fill_cnt  (fill_cnt),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Offer one sample, hold until accepted; returns 1 ns after the accept edge.
    task automatic send(input logic [7:0] d);
        int  n;
        logic took;
        n = 0;
        took = 1'b0;
        in_data = d;
        in_valid = 1'b1;
        while (!took && n < 200) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!took) begin
            checks++;
            failures++;
            $display("FAIL send_timeout data=%h", d);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clr = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (fill_cnt !== 4'd0) begin failures++; $display("FAIL reset_fill_cnt got=%0d exp=0", fill_cnt); end
        checks++; if (frame_cnt !== 16'd0) begin failures++; $display("FAIL reset_frame_cnt got=%h exp=0", frame_cnt); end
        checks++; if (out_data !== 64'd0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_basic_frame();
        logic [7:0] v [8];
        v = '{8'd1, 8'd2, 8'd12, 8'd8, 8'd4, 8'd10, 8'd6, 8'd3};
        out_ready = 1'b1;
        foreach (v[i]) send(v[i]);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_out_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 64'h03060A04080C0201) begin failures++; $display("FAIL basic_out_data got=%h exp=03060a04080c0201", out_data); end
        checks++; if (fill_cnt !== 4'd0) begin failures++; $display("FAIL basic_fill_cnt got=%0d exp=0", fill_cnt); end
        @(posedge clk); #1;
        checks++; if (frame_cnt !== 16'd1) begin failures++; $display("FAIL basic_frame_cnt got=%h exp=1", frame_cnt); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_drop got=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 15; i++) send(8'h10 + 8'(i));
        in_data = 8'h1F;
        in_valid = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_low got=%b exp=0", in_ready); end
        @(posedge clk); #1;
        checks++; if (fill_cnt !== 4'd7) begin failures++; $display("FAIL bp_fill_cnt got=%0d exp=7", fill_cnt); end
        checks++; if (out_data !== 64'h1716151413121110) begin failures++; $display("FAIL bp_hold_frame1 got=%h exp=1716151413121110", out_data); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_in_ready_comb got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_stays got=%b exp=1", out_valid); end
        checks++; if (out_data !== 64'h1F1E1D1C1B1A1918) begin failures++; $display("FAIL bp_frame2 got=%h exp=1f1e1d1c1b1a1918", out_data); end
        checks++; if (fill_cnt !== 4'd0) begin failures++; $display("FAIL bp_fill_wrap got=%0d exp=0", fill_cnt); end
        checks++; if (frame_cnt !== 16'd2) begin failures++; $display("FAIL bp_frame_cnt2 got=%h exp=2", frame_cnt); end
        @(posedge clk); #1;
        checks++; if (frame_cnt !== 16'd3) begin failures++; $display("FAIL bp_frame_cnt3 got=%h exp=3", frame_cnt); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_valid_drop got=%b exp=0", out_valid); end
    endtask

    task automatic test_clr();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(8'h21 + 8'(i));
        checks++; if (fill_cnt !== 4'd5) begin failures++; $display("FAIL clr_pre_fill got=%0d exp=5", fill_cnt); end
        in_data = 8'hEE;
        in_valid = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL clr_in_ready got=%b exp=0", in_ready); end
        @(posedge clk); #1;
        clr = 1'b0;
        in_valid = 1'b0;
        checks++; if (fill_cnt !== 4'd0) begin failures++; $display("FAIL clr_fill_cnt got=%0d exp=0", fill_cnt); end
        for (int i = 0; i < 8; i++) send(8'h31 + 8'(i));
        checks++; if (out_data !== 64'h3837363534333231) begin failures++; $display("FAIL clr_clean_frame got=%h exp=3837363534333231", out_data); end
        @(posedge clk); #1;
        checks++; if (frame_cnt !== 16'd4) begin failures++; $display("FAIL clr_frame_cnt got=%h exp=4", frame_cnt); end
        // clr against a pending frame with out_ready high: frame dropped, not counted
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(8'h41 + 8'(i));
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL clr_pending_valid got=%b exp=1", out_valid); end
        clr = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL clr_drop_valid got=%b exp=0", out_valid); end
        checks++; if (frame_cnt !== 16'd4) begin failures++; $display("FAIL clr_no_count got=%h exp=4", frame_cnt); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(8'h90 + 8'(i));
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (fill_cnt !== 4'd0) begin failures++; $display("FAIL ares_fill_cnt got=%0d exp=0", fill_cnt); end
        checks++; if (frame_cnt !== 16'd0) begin failures++; $display("FAIL ares_frame_cnt got=%h exp=0", frame_cnt); end
        checks++; if (out_data !== 64'd0) begin failures++; $display("FAIL ares_out_data got=%h exp=0", out_data); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ares_out_valid got=%b exp=0", out_valid); end
        #4;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) send(8'h51 + 8'(i));
        checks++; if (out_data !== 64'h5857565554535251) begin failures++; $display("FAIL ares_post_frame got=%h exp=5857565554535251", out_data); end
        @(posedge clk); #1;
        checks++; if (frame_cnt !== 16'd1) begin failures++; $display("FAIL ares_post_count got=%h exp=1", frame_cnt); end
    endtask

    task automatic test_wrap();
        out_ready = 1'b1;
        dut.frame_cnt_q = 16'hFFFE;
        #1;
        checks++; if (frame_cnt !== 16'hFFFE) begin failures++; $display("FAIL wrap_preload got=%h exp=fffe", frame_cnt); end
        for (int i = 0; i < 8; i++) send(8'h61 + 8'(i));
        @(posedge clk); #1;
        checks++; if (frame_cnt !== 16'hFFFF) begin failures++; $display("FAIL wrap_ffff got=%h exp=ffff", frame_cnt); end
        for (int i = 0; i < 8; i++) send(8'h69 + 8'(i));
        @(posedge clk); #1;
        checks++; if (frame_cnt !== 16'h0000) begin failures++; $display("FAIL wrap_zero got=%h exp=0000", frame_cnt); end
    endtask

    task automatic test_back_to_back();
        int start;
        out_ready = 1'b1;
        start = cyc;
        for (int i = 0; i < 16; i++) send(8'h71 + 8'(i));
        checks++; if (cyc - start != 16) begin failures++; $display("FAIL b2b_cycles got=%0d exp=16", cyc - start); end
        checks++; if (out_data !== 64'h807F7E7D7C7B7A79) begin failures++; $display("FAIL b2b_frame got=%h exp=807f7e7d7c7b7a79", out_data); end
        @(posedge clk); #1;
        checks++; if (frame_cnt !== 16'd2) begin failures++; $display("FAIL b2b_frame_cnt got=%h exp=2", frame_cnt); end
    endtask

`ifdef SLIDING_WINDOW_EN
    task automatic test_sliding();
        apply_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) send(8'(i));
        checks++; if (out_data !== 64'h0807060504030201) begin failures++; $display("FAIL slide_first got=%h exp=0807060504030201", out_data); end
        checks++; if (fill_cnt !== 4'd7) begin failures++; $display("FAIL slide_fill_sat got=%0d exp=7", fill_cnt); end
        send(8'd9);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL slide_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 64'h0908070605040302) begin failures++; $display("FAIL slide_second got=%h exp=0908070605040302", out_data); end
        checks++; if (fill_cnt !== 4'd7) begin failures++; $display("FAIL slide_fill_hold got=%0d exp=7", fill_cnt); end
        @(posedge clk); #1;
        checks++; if (frame_cnt !== 16'd2) begin failures++; $display("FAIL slide_frame_cnt got=%h exp=2", frame_cnt); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef SLIDING_WINDOW_EN
        test_sliding();
`else
        test_basic_frame();
        test_backpressure();
        test_clr();
        test_async_reset();
        test_wrap();
        test_back_to_back();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
